// File: rtl/cache_mem_ctrl.sv
// rtl/cache_mem_ctrl.sv - cache line-fill / write-back memory controller
//
// Accepts one cache-line request per transaction (fill or write-back) and
// moves it as LINE_W/MEM_W word beats over a request/acknowledge memory port.
// Optional beat timeout is enabled by defining MEM_CTRL_TIMEOUT_EN.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_valid_i, req_rw_i    request strobe, 1 = write-back / 0 = fill
//   req_addr_i, req_data_i   line byte address, line to write back
//   res_ready_o, res_data_o  completion pulse, last filled line
//   busy_o, err_o            transfer in progress, timeout abort pulse
//   mem_req_o, mem_we_o      beat request (held until ack), beat is a write
//   mem_addr_o, mem_wdata_o  beat byte address, beat write data
//   mem_ack_i, mem_rdata_i   beat accepted, beat read data

module cache_mem_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 128,
   parameter int MEM_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   input  logic              req_rw_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [LINE_W-1:0] req_data_i,
   output logic              res_ready_o,
   output logic [LINE_W-1:0] res_data_o,
   output logic              busy_o,
   output logic              err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [MEM_W-1:0]  mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [MEM_W-1:0]  mem_rdata_i
);

   localparam int BEATS  = LINE_W / MEM_W;
   localparam int CNT_W  = $clog2(BEATS);
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam int BOFF_W = $clog2(MEM_W / 8);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  beat_q;
   logic [ADDR_W-1:0] base_q;
   logic [LINE_W-1:0] line_q;
   logic [LINE_W-1:0] res_data_q;
   logic              res_ready_q;
   logic              busy_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [MEM_W-1:0]  mem_wdata_q;

   logic              accept_d;
   logic              beat_done_d;
   logic              last_beat_d;
   logic [CNT_W-1:0]  beat_nxt_d;
   logic [ADDR_W-1:0] req_base_d;
   logic [LINE_W-1:0] line_fill_d;

   // The line offset bits of the request address never reach the memory port.
   logic [OFF_W-1:0]  unused_addr_off;
   assign unused_addr_off = req_addr_i[OFF_W-1:0];

   always_comb begin
      accept_d    = req_valid_i && (state_q == S_IDLE || state_q == S_DONE);
      beat_done_d = mem_req_q && mem_ack_i;
      last_beat_d = (beat_q == CNT_W'(BEATS - 1));
      beat_nxt_d  = beat_q + CNT_W'(1);
      req_base_d  = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      // Line buffer with the current beat's read word merged in, so the final
      // beat's data is already part of the line stored into res_data.
      line_fill_d = line_q;
      line_fill_d[beat_q*MEM_W +: MEM_W] = mem_rdata_i;
   end

`ifdef MEM_CTRL_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   logic [WAIT_W-1:0] wait_q;
   logic              err_q;
   logic              timeout_d;
   // wait_q counts edges already spent waiting; abort on the TIMEOUT-th one.
   assign timeout_d = mem_req_q && !mem_ack_i && (wait_q == WAIT_W'(TIMEOUT - 1));
   assign err_o     = err_q;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
   assign err_o          = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         base_q      <= '0;
         line_q      <= '0;
         res_data_q  <= '0;
         res_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef MEM_CTRL_TIMEOUT_EN
         wait_q      <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         res_ready_q <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
         err_q       <= 1'b0;
`endif
         case (state_q)
            S_IDLE, S_DONE: begin
               state_q <= S_IDLE;
               if (accept_d) begin
                  state_q     <= req_rw_i ? S_WRITE : S_READ;
                  base_q      <= req_base_d;
                  line_q      <= req_data_i;
                  beat_q      <= '0;
                  busy_q      <= 1'b1;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= req_rw_i;
                  mem_addr_q  <= req_base_d;
                  mem_wdata_q <= req_data_i[MEM_W-1:0];
`ifdef MEM_CTRL_TIMEOUT_EN
                  wait_q      <= '0;
`endif
               end
            end
            S_WRITE, S_READ: begin
               if (beat_done_d) begin
`ifdef MEM_CTRL_TIMEOUT_EN
                  wait_q <= '0;
`endif
                  if (state_q == S_READ) line_q <= line_fill_d;
                  if (last_beat_d) begin
                     state_q     <= S_DONE;
                     res_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                     mem_req_q   <= 1'b0;
                     mem_we_q    <= 1'b0;
                     if (state_q == S_READ) res_data_q <= line_fill_d;
                  end else begin
                     // Next beat is presented on the same edge: no bubble.
                     beat_q      <= beat_nxt_d;
                     mem_addr_q  <= base_q + (ADDR_W'(beat_nxt_d) << BOFF_W);
                     mem_wdata_q <= line_q[beat_nxt_d*MEM_W +: MEM_W];
                  end
               end
`ifdef MEM_CTRL_TIMEOUT_EN
               else if (timeout_d) begin
                  // Abort: partial line is dropped, res_data keeps its old value.
                  state_q     <= S_DONE;
                  res_ready_q <= 1'b1;
                  err_q       <= 1'b1;
                  busy_q      <= 1'b0;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign res_ready_o = res_ready_q;
   assign res_data_o  = res_data_q;
   assign busy_o      = busy_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb/tb_cache_mem_ctrl.sv - self-checking bench for cache_mem_ctrl

module tb_cache_mem_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_rw;
   logic [31:0]   req_addr;
   logic [127:0]  req_data;
   logic          res_ready;
   logic [127:0]  res_data;
   logic          busy;
   logic          err;
   logic          mem_req;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack;
   logic [31:0]   mem_rdata;

   int n_vec = 0;
   int n_err = 0;
   int rdy_cnt = 0;

   always #5 clk = ~clk;

   cache_mem_ctrl #(
      .ADDR_W (32),
      .LINE_W (128),
      .MEM_W  (32),
      .TIMEOUT(8)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(req_valid),
      .req_rw_i   (req_rw),
      .req_addr_i (req_addr),
      .req_data_i (req_data),
      .res_ready_o(res_ready),
      .res_data_o (res_data),
      .busy_o     (busy),
      .err_o      (err),
      .mem_req_o  (mem_req),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_wdata_o(mem_wdata),
      .mem_ack_i  (mem_ack),
      .mem_rdata_i(mem_rdata)
   );

   always @(negedge clk) if (res_ready) rdy_cnt++;

   typedef struct {
      logic         rw;
      logic [31:0]  addr;
      logic [127:0] wline;
      logic [31:0]  rd_base;
      int           lat;
      logic [31:0]  exp_base;
      int           exp_done;
      logic [127:0] exp_res;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive a request for one cycle; returns at the negedge after the accept edge.
   task automatic issue_req(input logic rw, input logic [31:0] addr, input logic [127:0] line);
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = addr;
      req_data  = line;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Memory responder: acks each beat after lat wait cycles, checks beat
   // address/direction/data, and stops at the negedge where res_ready is seen.
   // Cycle n=1 is the first negedge after the accept edge.
   task automatic run_txn(input logic rw, input logic [31:0] base, input logic [127:0] wline,
                          input logic [31:0] rd_base, input int lat, input int inj_n,
                          output int done_n, output int beats);
      int w;
      w      = 0;
      beats  = 0;
      done_n = -1;
      for (int n = 1; n <= 200; n++) begin
         if (inj_n > 0) begin
            req_valid = (n == inj_n);
            req_rw    = 1'b1;
            req_addr  = 32'h0000_9990;
         end
         if (res_ready) begin
            done_n = n;
            break;
         end
         mem_ack = 1'b0;
         if (n == 1) chk("busy_during", busy, 1'b1);
         if (mem_req) begin
            if (w == lat) begin
               chk("beat_addr", mem_addr, base + 32'(beats * 4));
               chk("beat_we", mem_we, rw);
               if (rw) chk("beat_wdata", mem_wdata, wline[beats*32 +: 32]);
               mem_ack   = 1'b1;
               mem_rdata = rd_base + 32'(beats);
               beats++;
               w = 0;
            end else begin
               w++;
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      mem_ack   = 1'b0;
      req_valid = 1'b0;
      if (done_n < 0) chk("done_bound", 1'b0, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_n;
      int beats;
      int snap;
      logic [127:0] prev_res;

      vecs[0] = '{1'b0, 32'h0000_1234, 128'h0, 32'h0000_00A0, 0, 32'h0000_1230, 5,
                  128'h000000A3_000000A2_000000A1_000000A0};
      vecs[1] = '{1'b1, 32'h0000_4008, 128'h44443333_22221111_88887777_66665555, 32'h0, 2,
                  32'h0000_4000, 13, 128'h000000A3_000000A2_000000A1_000000A0};
      vecs[2] = '{1'b0, 32'hFFFF_FFFF, 128'h0, 32'h1000_0000, 1, 32'hFFFF_FFF0, 9,
                  128'h10000003_10000002_10000001_10000000};
      vecs[3] = '{1'b1, 32'h0000_0000, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 32'h0, 0,
                  32'h0000_0000, 5, 128'h10000003_10000002_10000001_10000000};
      vecs[4] = '{1'b0, 32'h8000_0017, 128'h0, 32'h5A5A_0000, 3, 32'h8000_0010, 17,
                  128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_rw    = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_res_ready", res_ready, 1'b0);
      chk("rst_res_data", res_data, 128'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);

      // Table-driven transactions
      for (int i = 0; i < 5; i++) begin
         issue_req(vecs[i].rw, vecs[i].addr, vecs[i].wline);
         run_txn(vecs[i].rw, vecs[i].exp_base, vecs[i].wline, vecs[i].rd_base,
                 vecs[i].lat, 0, done_n, beats);
         chk($sformatf("v%0d_done_cycle", i), 128'(done_n), 128'(vecs[i].exp_done));
         chk($sformatf("v%0d_beats", i), 128'(beats), 128'd4);
         chk($sformatf("v%0d_res_data", i), res_data, vecs[i].exp_res);
         chk($sformatf("v%0d_err", i), err, 1'b0);
         chk($sformatf("v%0d_busy_done", i), busy, 1'b0);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_pulse_len", i), res_ready, 1'b0);
      end

      // Write-back finishing while a fill is issued in the DONE cycle
      snap = rdy_cnt;
      issue_req(1'b1, 32'h0000_5000, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
      run_txn(1'b1, 32'h0000_5000, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 32'h0, 0, 0,
              done_n, beats);
      chk("b2b_wb_done", 128'(done_n), 128'd5);
      issue_req(1'b0, 32'h0000_2004, 128'h0);
      chk("b2b_gap_ready", res_ready, 1'b0);
      chk("b2b_gap_req", mem_req, 1'b1);
      chk("b2b_gap_we", mem_we, 1'b0);
      chk("b2b_gap_addr", mem_addr, 32'h0000_2000);
      run_txn(1'b0, 32'h0000_2000, 128'h0, 32'h0000_00C0, 0, 0, done_n, beats);
      chk("b2b_fill_done", 128'(done_n - 1), 128'd4);
      chk("b2b_fill_data", res_data, 128'h000000C3_000000C2_000000C1_000000C0);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_pulses", 128'(rdy_cnt - snap), 128'd2);

      // Reset asserted for one cycle while beat 2 of a fill is pending
      snap = rdy_cnt;
      issue_req(1'b0, 32'h0000_3000, 128'h0);
      for (int i = 0; i < 2; i++) begin
         mem_ack   = 1'b1;
         mem_rdata = 32'h77 + 32'(i);
         @(posedge clk);
         @(negedge clk);
      end
      mem_ack = 1'b0;
      rst_n   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("mrst_mem_req", mem_req, 1'b0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_res_ready", res_ready, 1'b0);
      chk("mrst_res_data", res_data, 128'h0);
      chk("mrst_mem_addr", mem_addr, 32'h0);
      chk("mrst_mem_we", mem_we, 1'b0);
      chk("mrst_mem_wdata", mem_wdata, 32'h0);
      chk("mrst_err", err, 1'b0);
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("mrst_no_pulse", 128'(rdy_cnt - snap), 128'd0);
      chk("mrst_stays_idle", mem_req, 1'b0);
      issue_req(1'b0, 32'h0000_3000, 128'h0);
      run_txn(1'b0, 32'h0000_3000, 128'h0, 32'h0000_0E00, 0, 0, done_n, beats);
      chk("mrst_refill_done", 128'(done_n), 128'd5);
      chk("mrst_refill_data", res_data, 128'h00000E03_00000E02_00000E01_00000E00);
      @(posedge clk);
      @(negedge clk);

      // Request strobe during READ is ignored
      snap = rdy_cnt;
      issue_req(1'b0, 32'h0000_6000, 128'h0);
      run_txn(1'b0, 32'h0000_6000, 128'h0, 32'h0000_0600, 1, 3, done_n, beats);
      chk("inj_done", 128'(done_n), 128'd9);
      chk("inj_beats", 128'(beats), 128'd4);
      chk("inj_data", res_data, 128'h00000603_00000602_00000601_00000600);
      @(posedge clk);
      @(negedge clk);
      chk("inj_no_second_req", mem_req, 1'b0);
      chk("inj_pulses", 128'(rdy_cnt - snap), 128'd1);

`ifdef MEM_CTRL_TIMEOUT_EN
      // Memory never acknowledges: abort after TIMEOUT=8 cycles of mem_req
      prev_res = res_data;
      issue_req(1'b0, 32'h0000_7000, 128'h0);
      mem_ack = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         chk($sformatf("to_wait%0d_err", n), err, 1'b0);
         chk($sformatf("to_wait%0d_req", n), mem_req, 1'b1);
         @(posedge clk);
         @(negedge clk);
      end
      chk("to_err", err, 1'b1);
      chk("to_res_ready", res_ready, 1'b1);
      chk("to_mem_req", mem_req, 1'b0);
      chk("to_res_data", res_data, prev_res);
      @(posedge clk);
      @(negedge clk);
      chk("to_err_pulse", err, 1'b0);
      chk("to_req_low", mem_req, 1'b0);
`else
      prev_res = res_data;
      chk("no_to_err", err, 1'b0);
      chk("no_to_res_data", res_data, prev_res);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cache_mem_ctrl.md
# cache_mem_ctrl

Line-fill/write-back memory controller sitting directly downstream of the cache controller FSM. It accepts one cache-line request (read = allocate, write = write-back), splits it into LINE_W/MEM_W word beats on a narrow request/acknowledge memory port, and returns a one-cycle `res_ready_o` pulse. On a read, `res_data_o` carries the assembled line during that pulse. It captures the single-cycle `req_valid_i` pulse the cache FSM issues, so the cache need not hold its request.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 128, cache line width in bits; multiple of MEM_W
- MEM_W, 32, memory word width; BEATS = LINE_W/MEM_W (power of two, ≥2)
- TIMEOUT, 255, max cycles a beat may wait for ack (only with MEM_CTRL_TIMEOUT_EN)

- clk_i  in  1  single clock; all state updates on rising edge
- rst_ni  in  1  synchronous, active-low reset
- req_valid_i  in  1  request strobe from cache FSM
- req_rw_i  in  1  1 = write-back line, 0 = line fill
- req_addr_i  in  ADDR_W  request byte address; offset bits ignored
- req_data_i  in  LINE_W  line to write back
- res_ready_o  out  1  one-cycle completion pulse
- res_data_o  out  LINE_W  filled line; valid during res_ready_o of a read
- busy_o  out  1  high in READ/WRITE states
- err_o  out  1  one-cycle timeout pulse (0 when feature compiled out)
- mem_req_o  out  1  beat request, held until acked
- mem_we_o  out  1  beat is a write
- mem_addr_o  out  ADDR_W  beat byte address
- mem_wdata_o  out  MEM_W  beat write data
- mem_ack_i  in  1  beat accepted/completed this cycle
- mem_rdata_i  in  MEM_W  read data, valid when mem_ack_i high

## Operation
- States: IDLE, WRITE, READ, DONE. All outputs registered.
- Accept: in IDLE or DONE, `req_valid_i`=1 latches rw, line base (req_addr_i with low log2(LINE_W/8) bits cleared), and req_data_i; beat counter := 0; next state WRITE (rw=1) or READ (rw=0). `req_valid_i` in READ/WRITE is ignored (not queued).
- Beat k: mem_addr_o = base + k·(MEM_W/8); mem_wdata_o = line word k (word 0 = bits [MEM_W-1:0]); mem_we_o = 1 in WRITE.
- A beat completes in any cycle with mem_req_o && mem_ack_i; on a read, mem_rdata_i is stored into word k of the line buffer that cycle.
- After the last beat (k = BEATS-1) completes: mem_req_o drops, state := DONE. Otherwise k increments, mem_req_o stays high (no bubble).
- DONE lasts one cycle: res_ready_o=1. Next state: IDLE, or READ/WRITE if a new request is accepted in that cycle (back-to-back write-back then fill).
- res_data_o holds the last filled line until the next read completes. It is not altered by writes.
- mem_ack_i while mem_req_o=0 is ignored.

## Timing
- Reset values: res_ready_o=0, res_data_o=0, busy_o=0, err_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; state IDLE; counters 0.
- Accept edge T0: mem_req_o high from T0+1.
- With ack returned in the same cycle as each request, res_ready_o is high at T0+BEATS+1. Each wait cycle adds one.
- Reset mid-transfer: the next edge returns to IDLE, mem_req_o deasserts, no res_ready_o, partial line discarded.
- Request arriving in the DONE cycle: accepted; res_ready_o still pulses that cycle, and mem_req_o for the new request is high in the next cycle.

## Configuration
- MEM_CTRL_TIMEOUT_EN defined: a wait counter resets on each beat completion and on accept. If mem_req_o has stayed high for TIMEOUT cycles without ack, the controller aborts:
  - err_o and res_ready_o pulse together for one cycle, in state DONE;
  - mem_req_o drops;
  - res_data_o is left unchanged.
- Undefined: no counter; err_o tied 0; the controller waits for ack indefinitely.

## Test plan
- Fill, zero-wait ack, addr 0x0000_1234, memory returns 0xA0,0xA1,0xA2,0xA3 -> beat addresses 0x1230/0x1234/0x1238/0x123C; res_ready_o at T0+5; res_data_o = 0x000000A3_000000A2_000000A1_000000A0.
- Write-back, addr 0x0000_4008, line 0x44443333_22221111_… with 2-cycle ack latency per beat -> mem_we_o=1; word0 at 0x4000 first; res_ready_o at T0+13.
- Write-back completing while the cache issues a fill in the DONE cycle -> fill accepted; mem_req_o high the next cycle with mem_we_o=0; exactly two res_ready_o pulses.
- rst_ni low for 1 cycle at beat 2 of a fill -> IDLE next edge; all outputs at reset values; no res_ready_o; a subsequent fill completes normally.
- req_valid_i pulsed during READ -> ignored; exactly BEATS beats issued.
- MEM_CTRL_TIMEOUT_EN, TIMEOUT=8, ack never asserted -> err_o and res_ready_o high together 8 cycles after mem_req_o rises; mem_req_o low next cycle.
